// File: rtl/painterengine_gpu_fifo_sc.sv
// Single-clock synchronous FIFO with standard or first-word-fall-through read, occupancy and almost flags.
// Optional sticky overflow/underflow error flags when PAINTERENGINE_GPU_FIFO_ERROR_EN is defined.
module painterengine_gpu_fifo_sc #(
  parameter int DATA_WIDTH         = 32,
  parameter int DEPTH              = 64,
  parameter int FWFT               = 0,
  parameter int ALMOST_FULL_LEVEL  = 60,
  parameter int ALMOST_EMPTY_LEVEL = 4
) (
  input  logic                         i_wire_clock,
  input  logic                         i_wire_reset,
  input  logic [DATA_WIDTH-1:0]        i_wire_data_in,
  input  logic                         i_wire_write,
  input  logic                         i_wire_read,
`ifdef PAINTERENGINE_GPU_FIFO_ERROR_EN
  input  logic                         i_wire_clear_error,
  output logic                         o_wire_overflow,
  output logic                         o_wire_underflow,
`endif
  output logic [DATA_WIDTH-1:0]        o_wire_data_out,
  output logic                         o_wire_data_valid,
  output logic                         o_wire_full,
  output logic                         o_wire_empty,
  output logic                         o_wire_almost_full,
  output logic                         o_wire_almost_empty,
  output logic [$clog2(DEPTH):0]       o_wire_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(ALMOST_EMPTY_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]         wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]         rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]         count_reg, count_next;
  logic                  full_reg, empty_reg, almost_full_reg, almost_empty_reg;
  logic [DATA_WIDTH-1:0] data_out_reg;
  logic                  data_valid_reg;
  logic                  rd_ok, wr_ok;

  // A write into a full FIFO is still accepted when a pop frees a slot the same edge.
  assign rd_ok = i_wire_read & ~empty_reg;
  assign wr_ok = i_wire_write & (~full_reg | rd_ok);

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (wr_ok) wr_ptr_next = wr_ptr_reg + 1'b1;
    if (rd_ok) rd_ptr_next = rd_ptr_reg + 1'b1;
    case ({wr_ok, rd_ok})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge i_wire_clock) begin
    if (i_wire_reset) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      full_reg         <= 1'b0;
      empty_reg        <= 1'b1;
      almost_full_reg  <= 1'b0;
      almost_empty_reg <= 1'b1;
    end else begin
      wr_ptr_reg       <= wr_ptr_next;
      rd_ptr_reg       <= rd_ptr_next;
      count_reg        <= count_next;
      full_reg         <= (count_next == DEPTH_C);
      empty_reg        <= (count_next == '0);
      almost_full_reg  <= (count_next >= AF_C);
      almost_empty_reg <= (count_next <= AE_C);
    end
  end

  // Storage is never cleared; only the pointers and count are reset.
  always_ff @(posedge i_wire_clock) begin
    if (!i_wire_reset && wr_ok) mem[wr_ptr_reg] <= i_wire_data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Registered head: prefetch the post-edge head, bypassing a word written straight into the head slot.
      always_ff @(posedge i_wire_clock) begin
        if (i_wire_reset) begin
          data_out_reg   <= '0;
          data_valid_reg <= 1'b0;
        end else begin
          data_valid_reg <= (count_next != '0);
          if (wr_ok && (wr_ptr_reg == rd_ptr_next)) data_out_reg <= i_wire_data_in;
          else                                      data_out_reg <= mem[rd_ptr_next];
        end
      end
    end else begin : g_std
      always_ff @(posedge i_wire_clock) begin
        if (i_wire_reset) begin
          data_out_reg   <= '0;
          data_valid_reg <= 1'b0;
        end else begin
          data_valid_reg <= rd_ok;
          if (rd_ok) data_out_reg <= mem[rd_ptr_reg];
        end
      end
    end
  endgenerate

`ifdef PAINTERENGINE_GPU_FIFO_ERROR_EN
  logic overflow_reg, underflow_reg;

  // A new error event wins over a clear in the same cycle.
  always_ff @(posedge i_wire_clock) begin
    if (i_wire_reset) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (i_wire_write & ~wr_ok)      overflow_reg <= 1'b1;
      else if (i_wire_clear_error)    overflow_reg <= 1'b0;
      if (i_wire_read & empty_reg)    underflow_reg <= 1'b1;
      else if (i_wire_clear_error)    underflow_reg <= 1'b0;
    end
  end

  assign o_wire_overflow  = overflow_reg;
  assign o_wire_underflow = underflow_reg;
`endif

  assign o_wire_data_out     = data_out_reg;
  assign o_wire_data_valid   = data_valid_reg;
  assign o_wire_full         = full_reg;
  assign o_wire_empty        = empty_reg;
  assign o_wire_almost_full  = almost_full_reg;
  assign o_wire_almost_empty = almost_empty_reg;
  assign o_wire_count        = count_reg;

endmodule
